vec_alu_issue_ctrl: RTL and testbench

//  Upstream sequencer and result collector for the Q7.8 vector ALU lanes in the execute stage.
//  - Accepts one vector/scalar ALU op per handshake.
//  - Time-multiplexes LANES operand lanes onto NUM_ALU combinational ALU instances.
//  - Captures lane results into a LANES-wide output register.
//  - Aggregates lane flags and presents result + flags to writeback via valid/ready.

---
 rtl/vec_alu_issue_ctrl_if.sv | 32 +++
 rtl/vec_alu_issue_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_vec_alu_issue_ctrl.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_alu_issue_ctrl_if.sv
// Op request and result channels between the issue sequencer, its upstream
// source and writeback. DUT side uses the slave modport.
interface vec_alu_issue_ctrl_if #(
  parameter int LANES  = 4,
  parameter int DATA_W = 16
);
  // Valid/ready: a transfer happens on a rising edge where valid and ready are
  // both high; the source holds its payload stable while valid is high and
  // ready is low. Valid may be withdrawn before a transfer has happened.
  logic                    in_valid;
  logic                    in_ready;
  logic [2:0]              in_opcode;
  logic                    in_scalar;
  logic [LANES*DATA_W-1:0] in_a;
  logic [LANES*DATA_W-1:0] in_b;
  logic [LANES*DATA_W-1:0] in_c;

  logic                    out_valid;
  logic                    out_ready;
  logic [LANES*DATA_W-1:0] out_result;
  logic [3:0]              out_flags;

  modport master (
    output in_valid, in_opcode, in_scalar, in_a, in_b, in_c, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_opcode, in_scalar, in_a, in_b, in_c, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/vec_alu_issue_ctrl.sv
// Vector ALU issue sequencer: time-multiplexes LANES operand lanes onto NUM_ALU
// ALUs, collects results and {V,N,Z,C} flags. Optional VEC_ISSUE_PERF_CNT_EN adds perf counters.
module vec_alu_issue_ctrl #(
  parameter int LANES   = 4,
  parameter int NUM_ALU = 1,
  parameter int DATA_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  vec_alu_issue_ctrl_if.slave       bus,
  output logic [NUM_ALU*DATA_W-1:0] alu_a,
  output logic [NUM_ALU*DATA_W-1:0] alu_b,
  output logic [NUM_ALU*DATA_W-1:0] alu_c,
  output logic [2:0]                alu_opcode,
  output logic                      alu_scalar,
  input  logic [NUM_ALU*DATA_W-1:0] alu_result,
  input  logic [NUM_ALU*4-1:0]      alu_flags,
`ifdef VEC_ISSUE_PERF_CNT_EN
  output logic [31:0]               perf_ops,
  output logic [31:0]               perf_ovf,
`endif
  output logic [1:0]                state_dbg
);

  localparam int BEATS  = LANES / NUM_ALU;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int W      = LANES * DATA_W;

  if ((LANES % NUM_ALU) != 0) begin : g_bad_cfg
    $error("vec_alu_issue_ctrl: NUM_ALU must divide LANES");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t              state;
  logic [BEAT_W-1:0]   beat;
  logic                primed;
  logic [W-1:0]        op_a, op_b, op_c;
  logic                acc_v, acc_n, acc_z, acc_c;

  logic [BEAT_W-1:0]   last_beat;
  logic [BEAT_W:0]     ld_beat;
  logic [NUM_ALU*DATA_W-1:0] ld_a, ld_b, ld_c;
  logic                nxt_v, nxt_n, nxt_z, nxt_c;
  logic                op_known;

  assign state_dbg = state;
  assign last_beat = alu_scalar ? '0 : BEAT_W'(BEATS - 1);
  assign op_known  = (alu_opcode == 3'b000) || (alu_opcode == 3'b001) ||
                     (alu_opcode == 3'b010) || (alu_opcode == 3'b111);

  // First ISSUE cycle only primes the ALU operand registers with beat 0;
  // each later cycle captures the current beat and primes the next one.
  always_comb begin
    int lane;
    lane    = 0;
    ld_a    = '0;
    ld_b    = '0;
    ld_c    = '0;
    ld_beat = primed ? ({1'b0, beat} + 1'b1) : '0;
    for (int j = 0; j < NUM_ALU; j++) begin
      lane = int'(ld_beat) * NUM_ALU + j;
      if ((ld_beat <= {1'b0, last_beat}) && (lane < LANES) && (!alu_scalar || j == 0)) begin
        ld_a[j*DATA_W +: DATA_W] = op_a[lane*DATA_W +: DATA_W];
        ld_b[j*DATA_W +: DATA_W] = op_b[lane*DATA_W +: DATA_W];
        ld_c[j*DATA_W +: DATA_W] = op_c[lane*DATA_W +: DATA_W];
      end
    end
  end

  // Flag accumulation for the beat on the ALU bus; only ALU0 counts for scalar ops.
  // Masking C with the opcode keeps an undriven mul carry out of the result.
  always_comb begin
    nxt_v = acc_v;
    nxt_n = acc_n;
    nxt_z = acc_z;
    nxt_c = acc_c;
    for (int j = 0; j < NUM_ALU; j++) begin
      if (!alu_scalar || j == 0) begin
        nxt_v = nxt_v | alu_flags[j*4+3];
        nxt_n = nxt_n | alu_flags[j*4+2];
        nxt_z = nxt_z & alu_flags[j*4+1];
        nxt_c = nxt_c | (alu_flags[j*4] & (alu_opcode != 3'b000));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      beat           <= '0;
      primed         <= 1'b0;
      op_a           <= '0;
      op_b           <= '0;
      op_c           <= '0;
      acc_v          <= 1'b0;
      acc_n          <= 1'b0;
      acc_z          <= 1'b0;
      acc_c          <= 1'b0;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_c          <= '0;
      alu_opcode     <= 3'b000;
      alu_scalar     <= 1'b0;
      bus.in_ready   <= 1'b1;
      bus.out_valid  <= 1'b0;
      bus.out_result <= '0;
      bus.out_flags  <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            op_a           <= bus.in_a;
            op_b           <= bus.in_b;
            op_c           <= bus.in_c;
            alu_opcode     <= bus.in_opcode;
            alu_scalar     <= bus.in_scalar;
            bus.out_result <= '0;
            acc_v          <= 1'b0;
            acc_n          <= 1'b0;
            acc_z          <= 1'b1;
            acc_c          <= 1'b0;
            beat           <= '0;
            primed         <= 1'b0;
            bus.in_ready   <= 1'b0;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          alu_a <= ld_a;
          alu_b <= ld_b;
          alu_c <= ld_c;
          if (!primed) begin
            primed <= 1'b1;
          end else begin
            for (int j = 0; j < NUM_ALU; j++) begin
              if (!alu_scalar || j == 0) begin
                bus.out_result[(int'(beat)*NUM_ALU + j)*DATA_W +: DATA_W] <=
                  alu_result[j*DATA_W +: DATA_W];
              end
            end
            acc_v <= nxt_v;
            acc_n <= nxt_n;
            acc_z <= nxt_z;
            acc_c <= nxt_c;
            if (beat == last_beat) begin
              bus.out_flags <= op_known ? {nxt_v, nxt_n, nxt_z, nxt_c} : 4'b0010;
              bus.out_valid <= 1'b1;
              state         <= DONE;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state         <= IDLE;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef VEC_ISSUE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops <= '0;
      perf_ovf <= '0;
    end else if (bus.out_valid && bus.out_ready) begin
      perf_ops <= perf_ops + 32'd1;
      if (bus.out_flags[3]) begin
        perf_ovf <= perf_ovf + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vec_alu_issue_ctrl.sv
// Directed, table-driven bench for vec_alu_issue_ctrl with a Q7.8 ALU stand-in
// on the ALU side; hand sequences cover backpressure, reset mid-op and idle out_ready.
module tb_vec_alu_issue_ctrl;
  localparam int LANES   = 4;
  localparam int NUM_ALU = 1;
  localparam int DATA_W  = 16;
  localparam int W       = LANES * DATA_W;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vec_alu_issue_ctrl_if #(.LANES(LANES), .DATA_W(DATA_W)) bus ();

  logic [NUM_ALU*DATA_W-1:0] alu_a, alu_b, alu_c, alu_result;
  logic [2:0]                alu_opcode;
  logic                      alu_scalar;
  logic [NUM_ALU*4-1:0]      alu_flags;
  logic [1:0]                state_dbg;
`ifdef VEC_ISSUE_PERF_CNT_EN
  logic [31:0]               perf_ops, perf_ovf;
`endif

  vec_alu_issue_ctrl #(.LANES(LANES), .NUM_ALU(NUM_ALU), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_c      (alu_c),
    .alu_opcode (alu_opcode),
    .alu_scalar (alu_scalar),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
`ifdef VEC_ISSUE_PERF_CNT_EN
    .perf_ops   (perf_ops),
    .perf_ovf   (perf_ovf),
`endif
    .state_dbg  (state_dbg)
  );

  // Q7.8 ALU stand-in; unknown opcodes return 0 with junk flags 1101.
  function automatic logic [19:0] alu_fn(input logic [2:0] op, input logic [15:0] a,
                                         input logic [15:0] b, input logic [15:0] c);
    logic [16:0] s;
    logic [31:0] p;
    logic [15:0] r;
    logic        v, cy;
    s = '0; p = '0; r = '0; v = 1'b0; cy = 1'b0;
    case (op)
      3'b010: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[15:0]; cy = s[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      3'b001: begin
        s = {1'b0, a} + {1'b0, ~b} + 17'd1;
        r = s[15:0]; cy = s[16];
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      3'b000: begin
        p  = $signed(a) * $signed(b);
        r  = p[23:8];
        cy = 1'b1;
        v  = !((&p[31:23]) || (~|p[31:23]));
      end
      3'b111: r = c;
      default: return 20'hD_0000;
    endcase
    return {v, r[15], (r == 16'd0), cy, r};
  endfunction

  always_comb begin
    alu_result = '0;
    alu_flags  = '0;
    for (int j = 0; j < NUM_ALU; j++) begin
      {alu_flags[j*4 +: 4], alu_result[j*DATA_W +: DATA_W]} =
        alu_fn(alu_opcode, alu_a[j*DATA_W +: DATA_W], alu_b[j*DATA_W +: DATA_W],
               alu_c[j*DATA_W +: DATA_W]);
    end
  end

  typedef struct {
    string        name;
    logic [2:0]   op;
    logic         scalar;
    logic [W-1:0] a, b, c;
    logic [W-1:0] res;
    logic [3:0]   flg;
  } vec_t;

  vec_t         vecs[$];
  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           errors = 0;
  int           ops_exp = 0;
  int           ovf_exp = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input string n, input logic [2:0] op, input logic sc,
                         input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                         input logic [W-1:0] res, input logic [3:0] flg);
    vec_t v;
    v.name = n; v.op = op; v.scalar = sc; v.a = a; v.b = b; v.c = c; v.res = res; v.flg = flg;
    vecs.push_back(v);
  endtask

  task automatic drive_op(input vec_t v);
    bus.in_valid  = 1'b1;
    bus.in_opcode = v.op;
    bus.in_scalar = v.scalar;
    bus.in_a      = v.a;
    bus.in_b      = v.b;
    bus.in_c      = v.c;
  endtask

  task automatic scramble_inputs();
    bus.in_a = {$urandom, $urandom};
    bus.in_b = {$urandom, $urandom};
    bus.in_c = {$urandom, $urandom};
    bus.in_opcode = 3'($urandom_range(0, 7));
  endtask

  // One op through accept, latency count, result check, optional hold, release.
  task automatic run_vec(input vec_t v, input int hold);
    int           cyc;
    int           exp_lat;
    logic [W-1:0] exp_r;
    exp_lat = v.scalar ? 2 : (LANES / NUM_ALU) + 1;
    @(negedge clk);
    check({v.name, " in_ready idle"}, 64'(bus.in_ready), 64'd1);
    drive_op(v);
    exp_q.push_back(v.res);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    scramble_inputs();
    check({v.name, " in_ready busy"}, 64'(bus.in_ready), 64'd0);
    cyc = 0;
    while (!bus.out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({v.name, " latency"}, 64'(cyc), 64'(exp_lat));
    exp_r = exp_q.pop_front();
    check({v.name, " result"}, 64'(bus.out_result), 64'(exp_r));
    check({v.name, " flags"}, 64'(bus.out_flags), 64'(v.flg));
    for (int k = 0; k < hold; k++) begin
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      check({v.name, " hold valid"}, 64'(bus.out_valid), 64'd1);
      check({v.name, " hold result"}, 64'(bus.out_result), 64'(exp_r));
      check({v.name, " hold in_ready"}, 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    ops_exp++;
    if (v.flg[3]) ovf_exp++;
    check({v.name, " out_valid drop"}, 64'(bus.out_valid), 64'd0);
    check({v.name, " back idle"}, 64'({state_dbg, bus.in_ready}), 64'({2'd0, 1'b1}));
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_opcode = 3'b000; bus.in_scalar = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_c = '0; bus.out_ready = 1'b0;

    add_vec("vadd", 3'b010, 1'b0, {4{16'h0100}}, {4{16'h0200}}, '0, {4{16'h0300}}, 4'b0000);
    add_vec("vmul", 3'b000, 1'b0, {16'hFE80, {3{16'h0180}}}, {4{16'h0200}}, '0,
            {16'hFD00, {3{16'h0300}}}, 4'b0100);
    add_vec("ssub", 3'b001, 1'b1, {{3{16'h1111}}, 16'h0100}, {{3{16'h2222}}, 16'h0200}, '0,
            {{3{16'h0000}}, 16'hFF00}, 4'b0100);
    add_vec("vadd_ovf", 3'b010, 1'b0, {16'h0000, 16'h7F00, 32'h0}, {16'h0000, 16'h0200, 32'h0}, '0,
            {16'h0000, 16'h8100, 32'h0}, 4'b1100);
    add_vec("vset_zero", 3'b111, 1'b0, {4{16'h1234}}, {4{16'h4321}}, '0, '0, 4'b0010);
    add_vec("vset_mix", 3'b111, 1'b0, '0, '0, {16'h1234, 16'h0000, 16'h8000, 16'h0001},
            {16'h1234, 16'h0000, 16'h8000, 16'h0001}, 4'b0100);
    add_vec("vadd_carry", 3'b010, 1'b0, {4{16'hFF00}}, {4{16'h0200}}, '0, {4{16'h0100}}, 4'b0001);
    add_vec("inval_011", 3'b011, 1'b0, {4{16'h1111}}, {4{16'h2222}}, '0, '0, 4'b0010);
    add_vec("inval_101", 3'b101, 1'b1, {4{16'h7777}}, {4{16'h5555}}, '0, '0, 4'b0010);
    add_vec("sadd_ovf", 3'b010, 1'b1, {{3{16'hFFFF}}, 16'h7F00}, {{3{16'h0000}}, 16'h0200}, '0,
            {48'h0, 16'h8100}, 4'b1100);
    add_vec("smul_zero", 3'b000, 1'b1, {{3{16'h0100}}, 16'h0000}, {{3{16'h0100}}, 16'h0200}, '0,
            '0, 4'b0010);

    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready", 64'(bus.in_ready), 64'd1);
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst out_result", 64'(bus.out_result), 64'd0);
    check("rst out_flags", 64'(bus.out_flags), 64'd0);
    check("rst alu regs", 64'({alu_a, alu_b, alu_c}), 64'd0);
    check("rst alu op", 64'({alu_opcode, alu_scalar}), 64'd0);
    check("rst state", 64'(state_dbg), 64'd0);
    rst = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i], 0);

    // Backpressure: out_ready low 10 cycles with a competing in_valid.
    run_vec(vecs[0], 10);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.out_valid || state_dbg != 2'd0) seen = 1'b1;
    end
    check("held in_valid ignored", 64'(seen), 64'd0);

    // out_ready while idle must not move anything.
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check("idle out_ready", 64'({state_dbg, bus.out_valid, bus.in_ready}), 64'({2'd0, 1'b0, 1'b1}));

`ifdef VEC_ISSUE_PERF_CNT_EN
    check("perf_ops", 64'(perf_ops), 64'(ops_exp));
    check("perf_ovf", 64'(perf_ovf), 64'(ovf_exp));
`endif

    // Reset during beat 2 of a vector op.
    @(negedge clk);
    drive_op(vecs[1]);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid-op state", 64'(state_dbg), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ops_exp = 0;
    ovf_exp = 0;
    check("midrst state", 64'(state_dbg), 64'd0);
    check("midrst out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst out_result", 64'(bus.out_result), 64'd0);
    check("midrst in_ready", 64'(bus.in_ready), 64'd1);
`ifdef VEC_ISSUE_PERF_CNT_EN
    check("midrst perf_ops", 64'(perf_ops), 64'd0);
`endif
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    check("discarded op silent", 64'(seen), 64'd0);

    run_vec(vecs[3], 0);
`ifdef VEC_ISSUE_PERF_CNT_EN
    check("perf_ops after rst", 64'(perf_ops), 64'(ops_exp));
    check("perf_ovf after rst", 64'(perf_ovf), 64'(ovf_exp));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
    $fatal(1);
  end

endmodule
